// File: rtl/apu_pkg.sv
// Shared definitions for the APU length counter bank: the 32-entry length
// lookup table and the 5-bit table index type.
package apu_pkg;

    typedef logic [4:0] apu_len_idx_t;

    localparam logic [7:0] APU_LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/apu_length_lut.sv
// Length lookup: maps the CPU-written 5-bit index to its 8-bit load value.
// One instance is shared by every channel of the bank.
module apu_length_lut
    import apu_pkg::*;
(
    input  apu_len_idx_t idx,
    output logic [7:0]   value
);

    // Pure table read, no state.
    always_comb begin
        value = APU_LENGTH_TABLE[idx];
    end

endmodule

// File: rtl/apu_length_counter_bank.sv
// Multi-channel APU length counter bank with a shared length table and a
// debug readback port.
// Optional macro APU_LENGTH_QUIRK_EN: 2A03 reload/clock collision (a load
// landing on a live, unhalted decrement is dropped) and a one-cycle delayed
// halt through the halt_q register. Undefined: load always wins and halt
// acts immediately.
module apu_length_counter_bank
    import apu_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int LENGTH_W = 8,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   length_en,
    input  logic [NUM_CH-1:0]   length_halt,
    input  logic                l_pulse,
    input  logic [4:0]          from_cpu,
    input  logic [NUM_CH-1:0]   length_wren,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [LENGTH_W-1:0] rd_length,
    output logic [NUM_CH-1:0]   active_out
);

    generate
        if (LENGTH_W < 8) begin : g_bad_width
            $error("apu_length_counter_bank: LENGTH_W must be at least 8");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("apu_length_counter_bank: NUM_CH must be in 1..8");
        end
    endgenerate

    logic [7:0]          lut_value;
    logic [LENGTH_W-1:0] load_value;
    logic [NUM_CH-1:0]   halt_eff;
    logic [NUM_CH-1:0][LENGTH_W-1:0] cnt_all;
    logic [LENGTH_W-1:0] rd_mux [2**SEL_W];

    apu_length_lut u_lut (
        .idx   (apu_len_idx_t'(from_cpu)),
        .value (lut_value)
    );

    assign load_value = LENGTH_W'(lut_value);

`ifdef APU_LENGTH_QUIRK_EN
    logic [NUM_CH-1:0] halt_q;
    logic [NUM_CH-1:0] halt_d;

    // Halt is sampled a cycle late, matching the 2A03 register path.
    always_comb begin
        halt_d = length_halt;
    end

    // Registered halt copy.
    always_ff @(posedge clk) begin
        if (rst) halt_q <= '0;
        else     halt_q <= halt_d;
    end

    assign halt_eff = halt_q;
`else
    assign halt_eff = length_halt;
`endif

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [LENGTH_W-1:0] cnt_q;
            logic [LENGTH_W-1:0] cnt_d;
            logic                dec_ok;

            // Next count: disable clears, then load, then decrement, else hold.
            always_comb begin
                dec_ok = l_pulse & ~halt_eff[i] & (cnt_q != '0);
                cnt_d  = cnt_q;
                if (!length_en[i]) begin
                    cnt_d = '0;
                end else if (length_wren[i]) begin
`ifdef APU_LENGTH_QUIRK_EN
                    // A live decrement on the same cycle swallows the load.
                    if (dec_ok) cnt_d = cnt_q - 1'b1;
                    else        cnt_d = load_value;
`else
                    cnt_d = load_value;
`endif
                end else if (dec_ok) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign cnt_all[i]    = cnt_q;
            assign active_out[i] = (cnt_q != '0);
        end

        // Pad the readback mux so unused select codes read as zero.
        for (genvar j = 0; j < 2**SEL_W; j++) begin : g_rd
            if (j < NUM_CH) begin : g_live
                assign rd_mux[j] = cnt_all[j];
            end else begin : g_pad
                assign rd_mux[j] = '0;
            end
        end
    endgenerate

    // Debug readback of the selected channel.
    always_comb begin
        rd_length = rd_mux[rd_sel];
    end

endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Scoreboard bench for apu_length_counter_bank. Stimulus pushes the expected
// post-edge readback into a queue; a monitor pops and compares after each edge.
// Build with or without APU_LENGTH_QUIRK_EN to match the RTL build.
module tb_apu_length_counter_bank;

    localparam int NUM_CH = 5;
    localparam int LW     = 8;
    localparam int SEL_W  = 3;
`ifdef APU_LENGTH_QUIRK_EN
    localparam bit QUIRK = 1'b1;
`else
    localparam bit QUIRK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] length_en;
    logic [NUM_CH-1:0] length_halt;
    logic              l_pulse;
    logic [4:0]        from_cpu;
    logic [NUM_CH-1:0] length_wren;
    logic [SEL_W-1:0]  rd_sel;
    logic [LW-1:0]     rd_length;
    logic [NUM_CH-1:0] active_out;

    apu_length_counter_bank #(.NUM_CH(NUM_CH), .LENGTH_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .length_en   (length_en),
        .length_halt (length_halt),
        .l_pulse     (l_pulse),
        .from_cpu    (from_cpu),
        .length_wren (length_wren),
        .rd_sel      (rd_sel),
        .rd_length   (rd_length),
        .active_out  (active_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0]     rd;
        logic [NUM_CH-1:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int tbl [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                     12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    int cnt   [NUM_CH];
    bit hprev [NUM_CH];

    // Apply one cycle of inputs and record what the counters should hold after the edge.
    task automatic drive(input bit r, input logic [NUM_CH-1:0] en,
                         input logic [NUM_CH-1:0] halt, input logic [NUM_CH-1:0] wren,
                         input bit lp, input int idx, input int sel);
        int   nxt [NUM_CH];
        exp_t e;
        @(negedge clk);
        rst         = r;
        length_en   = en;
        length_halt = halt;
        length_wren = wren;
        l_pulse     = lp;
        from_cpu    = idx[4:0];
        rd_sel      = sel[SEL_W-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            bit he;
            bit may_dec;
            he      = QUIRK ? hprev[i] : halt[i];
            may_dec = lp && !he && cnt[i] > 0;
            if (r || !en[i])            nxt[i] = 0;
            else if (wren[i] && !(QUIRK && may_dec)) nxt[i] = tbl[idx];
            else if (may_dec)           nxt[i] = cnt[i] - 1;
            else                        nxt[i] = cnt[i];
        end
        e.act = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]   = nxt[i];
            hprev[i] = r ? 1'b0 : halt[i];
            e.act[i] = (cnt[i] != 0);
        end
        e.rd = (sel < NUM_CH) ? LW'(cnt[sel]) : '0;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge produces an output to check once stimulus is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (rd_length !== e.rd || active_out !== e.act) begin
                    bad++;
                    $display("FAIL readback t=%0t sel=%0d: got rd=%0d act=%b, want rd=%0d act=%b",
                             $time, rd_sel, rd_length, active_out, e.rd, e.act);
                end
            end
        end
    end

    localparam logic [NUM_CH-1:0] ALL = '1;
    localparam logic [NUM_CH-1:0] NO  = '0;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]   = 0;
            hprev[i] = 1'b0;
        end
        rst = 1'b1; length_en = '0; length_halt = '0; l_pulse = 1'b0;
        from_cpu = '0; length_wren = '0; rd_sel = '0;

        // Reset, then enable and load ch0 with index 1 (254).
        drive(1, NO, NO, NO, 0, 0, 0);
        drive(1, ALL, NO, ALL, 1, 1, 0);
        drive(0, ALL, NO, NO, 0, 0, 0);
        drive(0, ALL, NO, 5'b00001, 0, 1, 0);
        drive(0, ALL, NO, NO, 0, 0, 0);

        // ch2 loads 2, then three pulses: 1, 0, stays 0.
        drive(0, ALL, NO, 5'b00100, 0, 3, 2);
        repeat (3) drive(0, ALL, NO, NO, 1, 0, 2);

        // Multi-load 192 into ch0, ch1, ch3; ch2 untouched.
        drive(0, ALL, NO, 5'b01011, 0, 24, 1);
        drive(0, ALL, NO, NO, 0, 0, 0);
        drive(0, ALL, NO, NO, 0, 0, 2);
        drive(0, ALL, NO, NO, 0, 0, 3);

        // ch3 to 5, then load+pulse collision.
        drive(0, ALL, NO, 5'b01000, 0, 7, 3);
        drive(0, ALL, NO, NO, 1, 0, 3);
        drive(0, ALL, NO, 5'b01000, 1, 0, 3);
        // Collision from 0 on ch4 always loads.
        drive(0, ALL, NO, 5'b10000, 1, 0, 4);

        // ch3 to 5, then halt in the pulse cycle, then pulse with halt held.
        drive(0, ALL, NO, 5'b01000, 0, 7, 3);
        drive(0, ALL, NO, NO, 1, 0, 3);
        drive(0, ALL, 5'b01000, NO, 1, 0, 3);
        drive(0, ALL, 5'b01000, NO, 1, 0, 3);
        drive(0, ALL, NO, NO, 0, 0, 3);

        // ch1 to 20, disable, load while disabled, reset during a load.
        drive(0, ALL, NO, 5'b00010, 0, 21, 1);
        drive(0, 5'b11101, NO, NO, 0, 0, 1);
        drive(0, 5'b11101, NO, 5'b00010, 0, 1, 1);
        drive(0, ALL, NO, 5'b00010, 1, 5, 1);
        drive(0, ALL, NO, NO, 0, 0, 1);
        drive(1, ALL, NO, ALL, 1, 5, 1);
        drive(0, ALL, NO, NO, 0, 0, 1);

        // Out-of-range select reads zero.
        drive(0, ALL, NO, ALL, 0, 8, 0);
        drive(0, ALL, NO, NO, 0, 0, 5);
        drive(0, ALL, NO, NO, 0, 0, 7);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [NUM_CH-1:0] en_r, halt_r, wren_r;
            for (int i = 0; i < NUM_CH; i++) begin
                en_r[i]   = ($urandom_range(0, 15) != 0);
                halt_r[i] = ($urandom_range(0, 5) == 0);
                wren_r[i] = ($urandom_range(0, 7) == 0);
            end
            drive(($urandom_range(0, 99) == 0), en_r, halt_r, wren_r,
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 31), $urandom_range(0, 7));
        end

        drive(0, ALL, NO, NO, 0, 0, 0);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
